uart_rx_core: RTL and testbench

UART_RX_CORE -- requirements
Module: uart_rx_core

---
 rtl/uart_rx_core.sv | 148 ++++++++++++++
 tb/tb_uart_rx_core.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_core.sv
// uart_rx_core: 16x-oversampling UART receiver with 2-of-3 majority bit voting,
//    optional even parity, framing-error and break detection.
// Latency: results are registered the clk after the stop-bit decision (tick count 9 of stop).
// Backpressure: none; rx_data_valid is a single-clk pulse that downstream must accept.
// Ports:
//    clk, reset (async, active-high), clk_enable (16x baud tick), parity_en, rx_uart (idle high)
//    rx_data[DATA_WIDTH-1:0], rx_data_valid (1-clk pulse), rx_data_error, rx_break
module uart_rx_core #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  clk_enable,
   input  logic                  parity_en,
   input  logic                  rx_uart,
   output logic [DATA_WIDTH-1:0] rx_data,
   output logic                  rx_data_valid,
   output logic                  rx_data_error,
   output logic                  rx_break
);

   localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP,
      WAIT_IDLE
   } state_t;

   state_t                r_state;
   logic                  r_sync1;
   logic                  r_sync2;
   logic [3:0]            r_tick_cnt;
   logic [BW-1:0]         r_bit_cnt;
   logic                  r_s7;
   logic                  r_s8;
   logic                  r_par_en;
   logic                  r_par_bit;
   logic [DATA_WIDTH-1:0] r_shift;

   logic w_rxs;
   logic w_maj;
   logic w_ferr;
   logic w_perr;
   logic w_brk;

   assign w_rxs  = r_sync2;
   // Majority of the count-7 and count-8 samples plus the live count-9 value.
   assign w_maj  = (r_s7 & r_s8) | (r_s7 & w_rxs) | (r_s8 & w_rxs);
   assign w_ferr = ~w_maj;
   assign w_perr = r_par_en & ((^r_shift) ^ r_par_bit);
   // Break: a stop-bit failure with an all-zero frame (parity bit included when present).
   assign w_brk  = w_ferr & ~(|r_shift) & (~r_par_en | ~r_par_bit);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state       <= IDLE;
         r_sync1       <= 1'b1;
         r_sync2       <= 1'b1;
         r_tick_cnt    <= 4'd0;
         r_bit_cnt     <= '0;
         r_s7          <= 1'b1;
         r_s8          <= 1'b1;
         r_par_en      <= 1'b0;
         r_par_bit     <= 1'b0;
         r_shift       <= '0;
         rx_data       <= '0;
         rx_data_valid <= 1'b0;
         rx_data_error <= 1'b0;
         rx_break      <= 1'b0;
      end else begin
         r_sync1       <= rx_uart;
         r_sync2       <= r_sync1;
         // The valid pulse is cleared on the very next clk, independent of the tick.
         rx_data_valid <= 1'b0;

         if (clk_enable) begin
            if (r_tick_cnt == 4'd7) r_s7 <= w_rxs;
            if (r_tick_cnt == 4'd8) r_s8 <= w_rxs;

            case (r_state)
               IDLE: begin
                  if (!w_rxs) begin
                     r_state    <= START;
                     r_tick_cnt <= 4'd0;
                     r_par_en   <= parity_en;
                     r_par_bit  <= 1'b0;
                  end
               end

               START: begin
                  r_tick_cnt <= r_tick_cnt + 4'd1;
                  if (r_tick_cnt == 4'd9 && w_maj) begin
                     // Glitch shorter than half a bit: not a real start bit.
                     r_state    <= IDLE;
                     r_tick_cnt <= 4'd0;
                  end else if (r_tick_cnt == 4'd15) begin
                     r_state   <= DATA;
                     r_bit_cnt <= '0;
                  end
               end

               DATA: begin
                  r_tick_cnt <= r_tick_cnt + 4'd1;
                  if (r_tick_cnt == 4'd9) r_shift <= {w_maj, r_shift[DATA_WIDTH-1:1]};
                  if (r_tick_cnt == 4'd15) begin
                     if (r_bit_cnt == LAST_BIT) r_state <= r_par_en ? PARITY : STOP;
                     else                       r_bit_cnt <= r_bit_cnt + 1'b1;
                  end
               end

               PARITY: begin
                  r_tick_cnt <= r_tick_cnt + 4'd1;
                  if (r_tick_cnt == 4'd9)  r_par_bit <= w_maj;
                  if (r_tick_cnt == 4'd15) r_state   <= STOP;
               end

               STOP: begin
                  r_tick_cnt <= r_tick_cnt + 4'd1;
                  if (r_tick_cnt == 4'd9) begin
                     // Leave early so a start edge during ticks 10..15 is caught from IDLE.
                     r_tick_cnt    <= 4'd0;
                     r_state       <= w_ferr ? WAIT_IDLE : IDLE;
                     rx_data       <= r_shift;
                     rx_data_valid <= 1'b1;
                     rx_data_error <= w_ferr | w_perr;
                     rx_break      <= w_brk;
                  end
               end

               WAIT_IDLE: begin
                  if (w_rxs) r_state <= IDLE;
               end

               default: begin
                  r_state    <= IDLE;
                  r_tick_cnt <= 4'd0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core: directed, table-driven bench for uart_rx_core.
// Frames are driven bit-by-bit at 16 ticks per bit; a negedge monitor queues every valid pulse.
module tb_uart_rx_core;

   logic       clk = 1'b0;
   logic       reset;
   logic       clk_enable;
   logic       parity_en;
   logic       rx_uart;
   logic [7:0] rx_data;
   logic       rx_data_valid;
   logic       rx_data_error;
   logic       rx_break;

   int checks = 0;
   int errors = 0;
   int div    = 4;

   logic [7:0] q_data[$];
   logic       q_err[$];
   logic       q_brk[$];

   typedef struct {
      string      name;
      logic       pen;
      logic [7:0] data;
      logic       pbit;
      logic       stop;
      logic [7:0] exp_data;
      logic       exp_err;
      logic       exp_brk;
   } vec_t;

   vec_t vecs[9];

   uart_rx_core #(.DATA_WIDTH(8)) dut (
      .clk           (clk),
      .reset         (reset),
      .clk_enable    (clk_enable),
      .parity_en     (parity_en),
      .rx_uart       (rx_uart),
      .rx_data       (rx_data),
      .rx_data_valid (rx_data_valid),
      .rx_data_error (rx_data_error),
      .rx_break      (rx_break)
   );

   always #5 clk = ~clk;

   // Tick generator: one clk_enable every div clks (div=1 holds it high).
   initial begin
      int c;
      c = 0;
      clk_enable = 1'b0;
      forever begin
         @(negedge clk);
         c = c + 1;
         if (c >= div) c = 0;
         clk_enable = (c == 0);
      end
   end

   // Pulse monitor sampled away from the active edge.
   initial begin
      forever begin
         @(negedge clk);
         if (rx_data_valid) begin
            q_data.push_back(rx_data);
            q_err.push_back(rx_data_error);
            q_brk.push_back(rx_break);
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks = checks + 1;
      if (act !== exp) begin
         errors = errors + 1;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic bit_time(input logic v);
      rx_uart = v;
      repeat (16 * div) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic pen, input logic pb, input logic stop);
      bit_time(1'b0);
      for (int i = 0; i < 8; i++) bit_time(d[i]);
      if (pen) bit_time(pb);
      bit_time(stop);
   endtask

   task automatic idle_bits(input int n);
      for (int i = 0; i < n; i++) bit_time(1'b1);
   endtask

   // Pops one queued report and compares it; an empty queue counts as a miss.
   task automatic expect_report(input string name, input logic [7:0] d, input logic e, input logic b);
      logic [31:0] ad;
      logic [31:0] ae;
      logic [31:0] ab;
      if (q_data.size() > 0) begin
         ad = {24'd0, q_data.pop_front()};
         ae = {31'd0, q_err.pop_front()};
         ab = {31'd0, q_brk.pop_front()};
      end else begin
         ad = 32'hDEAD;
         ae = 32'hDEAD;
         ab = 32'hDEAD;
      end
      check({name, ".data"}, ad, {24'd0, d});
      check({name, ".err"},  ae, {31'd0, e});
      check({name, ".brk"},  ab, {31'd0, b});
   endtask

   initial begin
      //          name         pen  data   pbit stop  exp_d  err  brk
      vecs[0] = '{"a5",        1'b0, 8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
      vecs[1] = '{"p03_bad",   1'b1, 8'h03, 1'b1, 1'b1, 8'h03, 1'b1, 1'b0};
      vecs[2] = '{"p03_good",  1'b1, 8'h03, 1'b0, 1'b1, 8'h03, 1'b0, 1'b0};
      vecs[3] = '{"brk_np",    1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1};
      vecs[4] = '{"pff_good",  1'b1, 8'hFF, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0};
      vecs[5] = '{"ferr_80",   1'b0, 8'h80, 1'b0, 1'b0, 8'h80, 1'b1, 1'b0};
      vecs[6] = '{"p00_pb1_f", 1'b1, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
      vecs[7] = '{"p00_brk",   1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1};
      vecs[8] = '{"p81_odd",   1'b1, 8'h81, 1'b1, 1'b1, 8'h81, 1'b1, 1'b0};

      reset     = 1'b1;
      parity_en = 1'b0;
      rx_uart   = 1'b1;
      repeat (5) @(negedge clk);
      check("rst.data",  {24'd0, rx_data}, 32'h0);
      check("rst.valid", {31'd0, rx_data_valid}, 32'h0);
      check("rst.err",   {31'd0, rx_data_error}, 32'h0);
      check("rst.brk",   {31'd0, rx_break}, 32'h0);
      reset = 1'b0;
      idle_bits(2);

      // Table-driven frames, one report expected per vector.
      for (int v = 0; v < 9; v++) begin
         parity_en = vecs[v].pen;
         send_frame(vecs[v].data, vecs[v].pen, vecs[v].pbit, vecs[v].stop);
         idle_bits(2);
         check({vecs[v].name, ".count"}, q_data.size(), 32'd1);
         expect_report(vecs[v].name, vecs[v].exp_data, vecs[v].exp_err, vecs[v].exp_brk);
      end
      parity_en = 1'b0;

      // Short low glitch: 5 ticks, no report, and previous outputs hold.
      rx_uart = 1'b0;
      repeat (5 * div) @(negedge clk);
      rx_uart = 1'b1;
      idle_bits(3);
      check("glitch.count", q_data.size(), 32'd0);
      check("glitch.hold_data", {24'd0, rx_data}, 32'h81);
      check("glitch.hold_err",  {31'd0, rx_data_error}, 32'h1);
      send_frame(8'h42, 1'b0, 1'b0, 1'b1);
      idle_bits(2);
      check("after_glitch.count", q_data.size(), 32'd1);
      expect_report("after_glitch", 8'h42, 1'b0, 1'b0);

      // Line held low for three frame times: a single break report.
      rx_uart = 1'b0;
      repeat (30 * 16 * div) @(negedge clk);
      idle_bits(2);
      check("held_low.count", q_data.size(), 32'd1);
      expect_report("held_low", 8'h00, 1'b1, 1'b1);
      send_frame(8'h5A, 1'b0, 1'b0, 1'b1);
      idle_bits(2);
      check("post_break.count", q_data.size(), 32'd1);
      expect_report("post_break", 8'h5A, 1'b0, 1'b0);

      // Back-to-back frames with a single stop bit between them.
      send_frame(8'h11, 1'b0, 1'b0, 1'b1);
      send_frame(8'hEE, 1'b0, 1'b0, 1'b1);
      idle_bits(2);
      check("b2b.count", q_data.size(), 32'd2);
      expect_report("b2b_first",  8'h11, 1'b0, 1'b0);
      expect_report("b2b_second", 8'hEE, 1'b0, 1'b0);

      // Reset during data bit 4 of a third frame.
      bit_time(1'b0);
      for (int i = 0; i < 4; i++) bit_time(1'b0);
      rx_uart = 1'b0;
      repeat (8 * div) @(negedge clk);
      reset   = 1'b1;
      rx_uart = 1'b1;
      repeat (3) @(negedge clk);
      check("midrst.data",  {24'd0, rx_data}, 32'h0);
      check("midrst.valid", {31'd0, rx_data_valid}, 32'h0);
      check("midrst.err",   {31'd0, rx_data_error}, 32'h0);
      check("midrst.brk",   {31'd0, rx_break}, 32'h0);
      reset = 1'b0;
      idle_bits(12);
      check("midrst.count", q_data.size(), 32'd0);
      check("midrst.hold_data", {24'd0, rx_data}, 32'h0);
      send_frame(8'h24, 1'b0, 1'b0, 1'b1);
      idle_bits(2);
      check("post_rst.count", q_data.size(), 32'd1);
      expect_report("post_rst", 8'h24, 1'b0, 1'b0);

      // clk_enable held permanently high: 16 clk per bit.
      div = 1;
      idle_bits(2);
      parity_en = 1'b1;
      send_frame(8'h96, 1'b1, 1'b0, 1'b1);
      idle_bits(2);
      check("en_high.count", q_data.size(), 32'd1);
      expect_report("en_high", 8'h96, 1'b0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
